vga_timing_monitor: RTL
=======================

# vga_timing_monitor

Synthesizable sink for the 1024x768@60 Hz VGA stream produced by the game's video pipeline, running on the 65 MHz pixel clock. Consumes `hs`, `vs` and 12-bit RGB, recovers pixel coordinates, and checks sync timing against the XGA constants. It then republishes active pixels with `x`/`y` for on-chip frame capture and self-check. It sits beside the top-level video output, tapping the same signals driven to the VGA connector.

## Interface
- `H_TOTAL`, 1344, pixel clocks per line
- `H_SYNC`, 136, hsync pulse width
- `H_BP`, 160, back porch after hsync
- `H_ACTIVE`, 1024, active pixels per line
- `V_TOTAL`, 806, lines per frame
- `V_SYNC`, 6, vsync width in lines
- `V_BP`, 29, back porch lines
- `V_ACTIVE`, 768, active lines
- `SYNC_POL`, 1'b0, asserted level of hs/vs (0 = active-low)

Ports:
- `clk` in 1 — 65 MHz pixel clock (the only clock)
- `rst` in 1 — synchronous, active-high reset
- `hs`, `vs` in 1 each — sync inputs
- `r`, `g`, `b` in 4 each — colour inputs
- `pix_valid` out 1 — active pixel on `x`/`y`/`rgb`
- `x` out 11 — column 0..1023
- `y` out 10 — row 0..767
- `rgb` out 12 — {r,g,b}
- `locked` out 1 — timing verified for one full frame
- `line_err` out 1 — one-cycle pulse, bad line period/hsync width
- `frame_err` out 1 — one-cycle pulse, bad line count per frame
- `frame_done` out 1 — one-cycle pulse after last active pixel
- `err_count` out 8 — saturating count of line_err+frame_err pulses
- `crc` out 16 — per-frame CRC (see Configuration)

## Operation
- All inputs registered once. Sync edge = registered transition into `SYNC_POL`.
- `hcnt`: cleared to 0 on hsync edge, otherwise +1, saturating at 2047. `hcnt` = 0 is the first cycle with hs asserted.
- `vcnt` updates on each hsync edge:
  - cleared to 0 if vs is asserted at that edge and was not asserted at the previous hsync edge;
  - otherwise +1, saturating at 1023.
- Active area: `hcnt` in [H_SYNC+H_BP, +H_ACTIVE), `vcnt` in [V_SYNC+V_BP, +V_ACTIVE). `x`/`y` are the offsets into that window.
- Line checks:
  - hsync deassertion at `hcnt` != H_SYNC-1 → line_err.
  - hsync edge with previous period != H_TOTAL → line_err.
  - `hcnt` reaching H_TOTAL with no edge → line_err once (lost hsync), then no further pulses until the next edge.
- Frame check: at each vsync frame start, lines since the previous frame start != V_TOTAL → frame_err.
- FSM:
  - SEARCH → MEASURE at first frame start.
  - MEASURE → LOCKED at the next frame start if no error occurred in between.
  - Any line_err or frame_err in MEASURE or LOCKED → SEARCH. The error pulse still fires.
  - The frame start that detects frame_err is not reused; relock waits for the next one.
- `locked` = (state == LOCKED). `pix_valid` and `frame_done` are asserted only when LOCKED.
- line_err and frame_err in the same cycle: both pulse, `err_count` += 2, saturating at 255.
- Errors are checked in every state, including SEARCH. The first frame start after reset has no reference period and produces no frame_err.

## Timing
- Latency: pixel on the input pins at cycle t appears on `pix_valid`/`x`/`y`/`rgb` at t+2.
- `frame_done` is asserted one cycle after the output beat x=1023, y=767.
- Reset values: all outputs 0; state SEARCH; counters 0.
- Reset asserted mid-frame: everything clears on the next edge. Relock takes at least one full frame plus the partial frame in progress.

## Configuration
- `VGA_MON_CRC_EN` defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF), 12 bits MSB-first per active pixel, one pixel per clock.
  - Re-initialised at frame start.
  - `crc` is latched in the same cycle as `frame_done`.
- Undefined: `crc` is constant 16'h0000 and no CRC logic is synthesized.

## Structure
- The XGA timing constants as localparams in shared package `vga_pkg`; parameter defaults reference them.
- FSM state enum `mon_state_t` {SEARCH, MEASURE, LOCKED} also lives in `vga_pkg`.
- One sub-module, `vga_crc16`, holding the CRC unrolled over 12 bits with clear and enable inputs. It is instantiated only under the macro.

## Test plan
- Two ideal XGA frames from the bench generator → `locked` rises at the second frame start. Third frame: 786432 `pix_valid` beats, first at x=0,y=0, with one `frame_done`.
- Pixel at (5,3) = 12'hABC → output x=5, y=3, rgb=12'hABC, two clocks after the input.
- Locked, one line shortened to 1343 clocks → one `line_err`, `locked`=0, `err_count`=1. Relock after two clean frame starts.
- Locked, hsync held deasserted for 3000 clocks → exactly one `line_err`.
- Frame with 805 lines → `frame_err` at the next frame start. `rst` pulsed mid-frame → all outputs 0 on the next cycle.
- Macro defined, constant-colour frame 12'h000 → `crc` equals the bench reference model value. Macro undefined → `crc`=0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: XGA 1024x768@60 timing constants and monitor state type.
// Shared by vga_timing_monitor and vga_crc16.
package vga_pkg;

    localparam int   XGA_H_TOTAL  = 1344;
    localparam int   XGA_H_SYNC   = 136;
    localparam int   XGA_H_BP     = 160;
    localparam int   XGA_H_ACTIVE = 1024;
    localparam int   XGA_V_TOTAL  = 806;
    localparam int   XGA_V_SYNC   = 6;
    localparam int   XGA_V_BP     = 29;
    localparam int   XGA_V_ACTIVE = 768;
    localparam logic XGA_SYNC_POL = 1'b0;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h1021;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } mon_state_t;

endpackage

// File: rtl/vga_crc16.sv
// vga_crc16: CRC-16-CCITT over one 12-bit pixel per clock, MSB first.
// Clear has priority over enable and reloads the init value.
module vga_crc16
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [11:0] data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Advance the running CRC by all 12 data bits in one cycle
    always_comb begin
        crc_d = crc_q;
        for (int i = 11; i >= 0; i--) begin
            if (crc_d[15] ^ data_i[i]) begin
                crc_d = {crc_d[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_d = {crc_d[14:0], 1'b0};
            end
        end
    end

    // CRC register: init on reset or clear, update on valid pixel
    always_ff @(posedge clk) begin
        if (rst_i || clr_i) begin
            crc_q <= CRC_INIT;
        end else if (en_i) begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: XGA sync checker and active-pixel republisher.
// Define VGA_MON_CRC_EN to add the per-frame CRC-16 on crc.
module vga_timing_monitor
    import vga_pkg::*;
#(
    parameter int   H_TOTAL  = XGA_H_TOTAL,
    parameter int   H_SYNC   = XGA_H_SYNC,
    parameter int   H_BP     = XGA_H_BP,
    parameter int   H_ACTIVE = XGA_H_ACTIVE,
    parameter int   V_TOTAL  = XGA_V_TOTAL,
    parameter int   V_SYNC   = XGA_V_SYNC,
    parameter int   V_BP     = XGA_V_BP,
    parameter int   V_ACTIVE = XGA_V_ACTIVE,
    parameter logic SYNC_POL = XGA_SYNC_POL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs,
    input  logic        vs,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    output logic        pix_valid,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic [11:0] rgb,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err,
    output logic        frame_done,
    output logic [7:0]  err_count,
    output logic [15:0] crc
);

    localparam logic [10:0] HCNT_MAX = 11'h7FF;
    localparam logic [9:0]  VCNT_MAX = 10'h3FF;
    localparam logic [10:0] HS_LAST  = 11'(H_SYNC - 1);
    localparam logic [10:0] HT_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] HT_FULL  = 11'(H_TOTAL);
    localparam logic [10:0] H_START  = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_END    = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] X_LAST   = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  VT_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_START  = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_END    = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0]  Y_LAST   = 10'(V_ACTIVE - 1);

    // stage 1: registered pins
    logic        hs_q;
    logic        hs_prev_q;
    logic        vs_q;
    logic [11:0] rgb_in_q;

    // coordinate and checker state
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        vs_last_q, vs_last_d;
    logic        hseen_q, hseen_d;
    logic        fseen_q, fseen_d;
    logic        lost_q, lost_d;
    mon_state_t  state_q, state_d;

    // stage 2: output registers
    logic        pix_valid_q, pix_valid_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [11:0] rgb_q, rgb_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  err_count_q, err_count_d;

    logic hs_on;
    logic hs_was;
    logic vs_on;
    logic h_edge;
    logic h_fall;
    logic frame_start;
    logic act;
    logic any_err;
    logic [8:0] err_sum;

    assign hs_on       = (hs_q == SYNC_POL);
    assign hs_was      = (hs_prev_q == SYNC_POL);
    assign vs_on       = (vs_q == SYNC_POL);
    assign h_edge      = hs_on && !hs_was;
    assign h_fall      = !hs_on && hs_was;
    assign frame_start = h_edge && vs_on && !vs_last_q;
    assign any_err     = line_err_d || frame_err_d;

    // Register the pins once; idle sync level is deasserted
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q      <= ~SYNC_POL;
            hs_prev_q <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            rgb_in_q  <= '0;
        end else begin
            hs_q      <= hs;
            hs_prev_q <= hs_q;
            vs_q      <= vs;
            rgb_in_q  <= {r, g, b};
        end
    end

    // Recover counters for the stage-1 pixel and flag sync errors
    always_comb begin
        hcnt_d      = (hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + 11'd1;
        vcnt_d      = vcnt_q;
        vs_last_d   = vs_last_q;
        hseen_d     = hseen_q;
        fseen_d     = fseen_q;
        lost_d      = lost_q;
        line_err_d  = 1'b0;
        frame_err_d = 1'b0;
        if (h_edge) begin
            hcnt_d    = '0;
            vs_last_d = vs_on;
            hseen_d   = 1'b1;
            lost_d    = 1'b0;
            // a lost line was already reported; skip its period
            if (hseen_q && !lost_q && hcnt_q != HT_LAST) begin
                line_err_d = 1'b1;
            end
            if (frame_start) begin
                vcnt_d  = '0;
                fseen_d = 1'b1;
                if (fseen_q && vcnt_q != VT_LAST) begin
                    frame_err_d = 1'b1;
                end
            end else begin
                vcnt_d = (vcnt_q == VCNT_MAX) ? vcnt_q : vcnt_q + 10'd1;
            end
        end else if (hseen_q && !lost_q && hcnt_d == HT_FULL) begin
            lost_d     = 1'b1;
            line_err_d = 1'b1;
        end
        if (h_fall && hseen_q && hcnt_q != HS_LAST) begin
            line_err_d = 1'b1;
        end
    end

    // Counter and checker state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            vs_last_q <= 1'b0;
            hseen_q   <= 1'b0;
            fseen_q   <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            vs_last_q <= vs_last_d;
            hseen_q   <= hseen_d;
            fseen_q   <= fseen_d;
            lost_q    <= lost_d;
        end
    end

    // Lock FSM: an erroring frame start never advances the state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEARCH: begin
                if (frame_start && !any_err) state_d = MEASURE;
            end
            MEASURE: begin
                if (any_err) state_d = SEARCH;
                else if (frame_start) state_d = LOCKED;
            end
            LOCKED: begin
                if (any_err) state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
    end

    // Lock state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Active window, output beat, frame end and error tally
    always_comb begin
        act = (hcnt_d >= H_START) && (hcnt_d < H_END) &&
              (vcnt_d >= V_START) && (vcnt_d < V_END);
        pix_valid_d = act && (state_d == LOCKED);
        x_d         = pix_valid_d ? hcnt_d - H_START : '0;
        y_d         = pix_valid_d ? vcnt_d - V_START : '0;
        rgb_d       = pix_valid_d ? rgb_in_q : '0;
        frame_done_d = pix_valid_q && (x_q == X_LAST) && (y_q == Y_LAST);
        err_sum = {1'b0, err_count_q} + {8'd0, line_err_d}
                + {8'd0, frame_err_d};
        err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid_q  <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            rgb_q        <= '0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            pix_valid_q  <= pix_valid_d;
            x_q          <= x_d;
            y_q          <= y_d;
            rgb_q        <= rgb_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
            frame_done_q <= frame_done_d;
            err_count_q  <= err_count_d;
        end
    end

`ifdef VGA_MON_CRC_EN
    logic [15:0] crc_run;
    logic [15:0] crc_q;

    vga_crc16 u_crc (
        .clk    (clk),
        .rst_i  (rst),
        .clr_i  (frame_start),
        .en_i   (act),
        .data_i (rgb_in_q),
        .crc_o  (crc_run)
    );

    // Hold the finished frame's CRC alongside frame_done
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= '0;
        end else if (frame_done_d) begin
            crc_q <= crc_run;
        end
    end

    assign crc = crc_q;
`else
    assign crc = 16'h0000;
`endif

    assign pix_valid  = pix_valid_q;
    assign x          = x_q;
    assign y          = y_q;
    assign rgb        = rgb_q;
    assign locked     = (state_q == LOCKED);
    assign line_err   = line_err_q;
    assign frame_err  = frame_err_q;
    assign frame_done = frame_done_q;
    assign err_count  = err_count_q;

endmodule
